// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with a valid/ready handshake, flush and bubble insertion.
// SKID=1 adds a second entry so that in_ready comes straight from a flop.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter bit               SKID   = 1'b0,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_ready && !out_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;

  if (SKID == 1'b0) begin : g_single
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign in_ready = !valid_q || out_ready;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
        valid_d = 1'b0;
        data_d  = BUBBLE;
      end else if (in_ready) begin
        valid_d = in_valid;
        data_d  = in_valid ? in_data : BUBBLE;
      end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
        valid_q <= 1'b0;
        data_q  <= BUBBLE;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

  end else begin : g_skid
    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q;

    // State register; in_ready is registered from the next state.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
        state_q <= StEmpty;
        main_q  <= BUBBLE;
        skid_q  <= BUBBLE;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        rdy_q   <= (state_d != StSkid);
      end
    end

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
        StEmpty: begin
          if (in_valid) begin
            state_d = StFull;
            main_d  = in_data;
          end
        end
        StFull: begin
          if (out_ready) begin
            state_d = in_valid ? StFull : StEmpty;
            main_d  = in_valid ? in_data : BUBBLE;
          end else if (in_valid) begin
            state_d = StSkid;
            skid_d  = in_data;
          end
        end
        StSkid: begin
          if (out_ready) begin
            state_d = StFull;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
      if (flush) begin
        state_d = StEmpty;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end
    end

    // main_q is forced to BUBBLE whenever the stage empties, so out_data needs no mux.
    always_comb begin
      out_valid = (state_q != StEmpty);
      out_data  = main_q;
      in_ready  = rdy_q;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register; the successor to the fixed-field per-stage registers (if/id, id/exe, exe/mem, ...).
- Carries one opaque payload bus of WIDTH bits under a valid/ready handshake instead of a global stall vector.
- Supports flush, and automatic bubble (NOP payload) insertion when a slot is empty.
- Optional 2-entry skid mode registers in_ready to break the combinational stall path, plus a saturating bubble counter for performance analysis.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- BUBBLE, {WIDTH{1'b0}}, payload value driven on out_data whenever out_valid=0; the NOP encoding.
- SKID, 0, 0 = single register with combinational in_ready; 1 = main+skid entries with registered in_ready.
- CNT_W, 16, bubble counter width (>=1).

Ports:
- cpu_clk_50M  in  1  clock; all state updates on rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream stage holds a valid payload.
- in_ready  out  1  stage accepts the payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid payload.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  WIDTH  payload to next stage; equals BUBBLE when out_valid=0.
- flush  in  1  synchronous kill of all held entries (exception/branch redirect).
- cnt_clr  in  1  synchronous clear of bubble_cnt.
- bubble_cnt  out  CNT_W  count of cycles with out_ready=1 and out_valid=0; saturating.

Behaviour:
- Reset (async, cpu_rst_n=0): out_valid=0, out_data=BUBBLE, skid entry empty, bubble_cnt=0, in_ready=1. Release takes effect on the next rising edge.
- Transfer rules: input handshake fires when in_valid & in_ready; output handshake fires when out_valid & out_ready.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - At each edge, if in_ready: out_valid<=in_valid, out_data<=in_valid ? in_data : BUBBLE.
  - Otherwise hold. Latency 1 cycle; full throughput.
- SKID=1: in_ready is a flop equal to (state != SKID). States:
  - EMPTY: in_valid -> FULL, main<=in_data.
  - FULL, out_ready=1: with in_valid -> FULL, main<=in_data; without in_valid -> EMPTY.
  - FULL, out_ready=0: with in_valid -> SKID, skid<=in_data; otherwise hold.
  - SKID: out_ready -> FULL, main<=skid. in_valid is ignored because in_ready=0.
  - out_valid = (state != EMPTY); out_data = main entry.
  - Latency 1 cycle; full throughput; no payload lost or duplicated when out_ready toggles every cycle.
- Flush: highest priority after reset.
  - Next state EMPTY, out_valid<=0, out_data<=BUBBLE, skid discarded, in_ready<=1.
  - Any input presented in the flush cycle is dropped, even if in_ready=1.
  - Flush does not affect bubble_cnt.
- Bubble counter:
  - Increments by 1 on each edge where out_ready=1 and out_valid=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr sets it to 0 and takes priority over an increment in the same cycle.
- Payload is opaque; no arithmetic on in_data. out_data is always registered; no combinational in->out path in either mode.
- Mid-operation reset clears all state immediately, regardless of handshake status.

Test Plan:
- Reset: hold cpu_rst_n=0 with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, out_data=0, bubble_cnt=0 throughout; first edge after release with in_valid=1 -> out_data=32'hDEADBEEF.
- SKID=1 backpressure: stream 1,2,3,4 with out_ready low during cycles 2-3 -> in_ready drops one cycle after 3 enters skid; output sequence is exactly 1,2,3,4 with no loss or duplication.
- Flush in SKID state holding 5 and 6, plus in_valid=1, in_data=7 in the flush cycle -> next cycle out_valid=0, out_data=BUBBLE, in_ready=1; values 5, 6 and 7 never appear at the output.
- SKID=0 stall: out_valid=1, out_data=8'hA5, out_ready=0, in_valid=1 -> in_ready=0 the same cycle; out_data stays 8'hA5 until out_ready=1.
- Bubble counter with CNT_W=3: out_ready=1, in_valid=0 for 10 cycles -> bubble_cnt 1..7 then holds at 7; cnt_clr asserted together with an increment condition -> bubble_cnt=0.
- Async reset mid-stream in SKID state: assert cpu_rst_n=0 between clock edges -> out_valid=0 and in_ready=1 immediately, without waiting for an edge.
